// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of a 4-bit combinational ALU.
// Commands {op, a, b, chain} are buffered in a DEPTH-entry FIFO and issued
// one at a time to the ALU. The ALU result and carry are captured and
// presented downstream over a valid/ready handshake. A chained command uses
// the previous captured result in place of cmd_a.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (cmd_op, cmd_a, cmd_b, cmd_chain)
//   alu_a/alu_b/alu_select  registered operands and opcode to the ALU
//   alu_out/alu_carry       ALU result and carry (combinational from the above)
//   res_valid/res_ready     result handshake (res_data, res_carry)
//   fifo_count              number of buffered commands
module alu_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic                     cmd_chain,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_select,
  input  logic [3:0]               alu_out,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_data,
  output logic                     res_carry,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       chain;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          cmd_in, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    acc;
  logic          push, pop, nonempty;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};
  assign head      = mem[rd_ptr];
  assign nonempty  = (fifo_count != '0);
  assign cmd_ready = (fifo_count != FULL) && !reset;
  assign push      = cmd_valid && cmd_ready;

  // Pops only look at the registered count, so a command written this cycle
  // is never issued before the following edge.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (nonempty) begin
        pop       = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = OUT;
      OUT: if (res_ready) begin
        if (nonempty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command FIFO; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cmd_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Operand load, result capture and result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      acc        <= '0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      if (pop) begin
        alu_a      <= head.chain ? acc : head.a;
        alu_b      <= head.b;
        alu_select <= head.op;
      end
      if (state == EXEC) begin
        res_data  <= alu_out;
        // The ALU carry is only meaningful for ADD.
        res_carry <= (alu_select == 2'b11) && alu_carry;
        acc       <= alu_out;
        res_valid <= 1'b1;
      end else if (state == OUT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: directed commands push hand-computed expected
// {carry, data} into a queue; a monitor pops and compares on each result
// handshake. A small ALU model closes the loop on alu_a/alu_b/alu_select.
module tb_alu_cmd_seq;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_select;
  logic       alu_carry;
  logic       res_valid, res_ready, res_carry;
  logic [3:0] res_data;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q [$];
  logic [4:0] mon_e;
  logic [4:0] sum;

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // ALU model; carry always reflects a+b so non-ADD masking is exercised.
  always_comb begin
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = sum[4];
    alu_out   = '0;
    case (alu_select)
      2'b00: alu_out = alu_a & alu_b;
      2'b01: alu_out = alu_a | alu_b;
      2'b10: alu_out = alu_a ^ alu_b;
      default: alu_out = sum[3:0];
    endcase
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: sampled mid-low-phase, the handshake happens at the next edge.
  always @(negedge clk) begin
    #2;
    if (!reset && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %0h/%0b expected none", res_data, res_carry);
      end else begin
        mon_e = exp_q.pop_front();
        if ({res_carry, res_data} !== mon_e) begin
          errors++;
          $display("FAIL result: got carry=%0b data=%0h expected carry=%0b data=%0h",
                   res_carry, res_data, mon_e[4], mon_e[3:0]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ch, input logic [4:0] exp);
    int t = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got cmd_ready=0 expected 1");
    end else begin
      exp_q.push_back(exp);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || res_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", 8'(t < 100), 8'd1);
    @(negedge clk);
  endtask

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_chain = 0;
    res_ready = 0; reset = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
    chk("rst_res_valid", 8'(res_valid), 8'd0);
    chk("rst_res_data", 8'(res_data), 8'd0);
    chk("rst_res_carry", 8'(res_carry), 8'd0);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_alu_b", 8'(alu_b), 8'd0);
    chk("rst_alu_select", 8'(alu_select), 8'd0);
    chk("rst_fifo_count", 8'(fifo_count), 8'd0);
    reset = 0;
    #1 chk("cmd_ready_after_rst", 8'(cmd_ready), 8'd1);
    @(negedge clk);

    // Single ADD with latency, then XOR (carry masked).
    res_ready = 1;
    send(2'b11, 4'h9, 4'h8, 1'b0, 5'h11);
    chk("lat_n_valid", 8'(res_valid), 8'd0);
    chk("lat_n_count", 8'(fifo_count), 8'd1);
    @(negedge clk);
    chk("lat_n1_valid", 8'(res_valid), 8'd0);
    chk("lat_n1_alu_a", 8'(alu_a), 8'h9);
    chk("lat_n1_alu_b", 8'(alu_b), 8'h8);
    chk("lat_n1_sel", 8'(alu_select), 8'd3);
    chk("lat_n1_count", 8'(fifo_count), 8'd0);
    @(negedge clk);
    chk("lat_n2_valid", 8'(res_valid), 8'd1);
    send(2'b10, 4'hF, 4'hA, 1'b0, 5'h05);
    drain();

    // Chaining: 3+4=7, 7^5=2, 2&6=2; cmd_a ignored when chained.
    send(2'b11, 4'h3, 4'h4, 1'b0, 5'h07);
    send(2'b10, 4'hF, 4'h5, 1'b1, 5'h02);
    send(2'b00, 4'h9, 4'h6, 1'b1, 5'h02);
    drain();

    // Backpressure: 5 commands fill the FIFO behind the one in flight.
    res_ready = 0;
    send(2'b11, 4'h1, 4'h2, 1'b0, 5'h03);
    send(2'b01, 4'h4, 4'h1, 1'b0, 5'h05);
    send(2'b10, 4'h6, 4'h3, 1'b0, 5'h05);
    send(2'b00, 4'hC, 4'hA, 1'b0, 5'h08);
    send(2'b11, 4'hF, 4'h2, 1'b0, 5'h11);
    chk("full_count", 8'(fifo_count), 8'd4);
    chk("full_cmd_ready", 8'(cmd_ready), 8'd0);
    fork
      send(2'b01, 4'h8, 4'h1, 1'b0, 5'h09);
      begin
        for (int k = 0; k < 3; k++) begin
          chk("stall_valid", 8'(res_valid), 8'd1);
          chk("stall_data", 8'(res_data), 8'h3);
          @(negedge clk);
        end
        res_ready = 1;
        for (int k = 0; k < 11; k++) begin
          @(negedge clk);
          chk("b2b_valid_pattern", 8'(res_valid), 8'(k % 2));
        end
      end
    join
    drain();

    // Simultaneous push and pop at count 2.
    res_ready = 0;
    send(2'b11, 4'h2, 4'h2, 1'b0, 5'h04);
    send(2'b00, 4'hF, 4'h3, 1'b0, 5'h03);
    send(2'b01, 4'h0, 4'h0, 1'b0, 5'h00);
    chk("pp_count_before", 8'(fifo_count), 8'd2);
    chk("pp_valid_before", 8'(res_valid), 8'd1);
    res_ready = 1;
    send(2'b10, 4'h5, 4'h5, 1'b0, 5'h00);
    chk("pp_count_after", 8'(fifo_count), 8'd2);
    drain();

    // Pointer wrap: 10 ADDs of i+i back-to-back.
    for (int i = 0; i < 10; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(2'b11, v, v, 1'b0, {v[3], v[2:0], 1'b0});
    end
    drain();

    // Reset while in OUT with 3 buffered commands.
    res_ready = 0;
    send(2'b11, 4'h7, 4'h7, 1'b0, 5'h0E);
    send(2'b11, 4'h1, 4'h1, 1'b0, 5'h02);
    send(2'b11, 4'h2, 4'h1, 1'b0, 5'h03);
    send(2'b11, 4'h3, 4'h1, 1'b0, 5'h04);
    chk("prerst_count", 8'(fifo_count), 8'd3);
    chk("prerst_valid", 8'(res_valid), 8'd1);
    reset = 1;
    exp_q.delete();
    #1 chk("inrst_cmd_ready", 8'(cmd_ready), 8'd0);
    @(negedge clk);
    reset = 0;
    chk("postrst_valid", 8'(res_valid), 8'd0);
    chk("postrst_count", 8'(fifo_count), 8'd0);
    chk("postrst_data", 8'(res_data), 8'd0);
    chk("postrst_alu_a", 8'(alu_a), 8'd0);
    res_ready = 1;
    send(2'b11, 4'hF, 4'h3, 1'b1, 5'h03);
    drain();

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
